// File: rtl/grf_mp_if.sv
// Bundle of the register-file access signals shared by decode, writeback and the MD unit.
// The master side drives addresses, write data and issue; the slave side (register file) answers.
interface grf_mp_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_pend;
  logic              wr0_en;
  logic [AW-1:0]     wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              wr_conflict;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
    input  rd_data, rd_pend, wr_conflict
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
    output rd_data, rd_pend, wr_conflict
  );
endinterface

// File: rtl/grf_mp.sv
// Multi-port GPR file: NRD combinational read ports, two write ports (WB, MD unit),
// optional write-to-read bypass and a per-register pending scoreboard for the hazard unit.
module grf_mp #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     reset,
  grf_mp_if.slave  bus
);
  localparam int DEPTH = 1 << AW;
  localparam bit BYP   = (BYPASS != 0);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;
  logic             we0;
  logic             we1;
  logic             same_addr;

  // Register 0 is hardwired: writes and issue to it never take effect.
  assign we0       = bus.wr0_en && (bus.wr0_addr != '0);
  assign we1       = bus.wr1_en && (bus.wr1_addr != '0);
  assign same_addr = (bus.wr0_addr == bus.wr1_addr);

  always_comb begin
    pend_next = pend;
    if (we0) pend_next[bus.wr0_addr] = 1'b0;
    if (we1) pend_next[bus.wr1_addr] = 1'b0;
    // A newly issued producer supersedes the one retiring this cycle.
    if (bus.iss_en && (bus.iss_addr != '0)) pend_next[bus.iss_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // NOTE: the array is plain flops rather than a RAM, so clearing it in reset is legal and cheap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      pend        <= '0;
      bus.wr_conflict <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
      if (we1 && !(we0 && same_addr)) regs[bus.wr1_addr] <= bus.wr1_data;
      if (we0)                        regs[bus.wr0_addr] <= bus.wr0_data;
      pend            <= pend_next;
      bus.wr_conflict <= we0 && we1 && same_addr;
    end
  end

  logic [NRD*DW-1:0] rd_data_c;
  logic [NRD-1:0]    rd_pend_c;
  logic [AW-1:0]     a;
  logic              hit0;
  logic              hit1;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    a         = '0;
    hit0      = 1'b0;
    hit1      = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a    = bus.rd_addr[k*AW +: AW];
      hit0 = BYP && we0 && (bus.wr0_addr == a);
      hit1 = BYP && we1 && (bus.wr1_addr == a);
      if (a != '0) begin
        if (hit0)      rd_data_c[k*DW +: DW] = bus.wr0_data;
        else if (hit1) rd_data_c[k*DW +: DW] = bus.wr1_data;
        else           rd_data_c[k*DW +: DW] = regs[a];
        rd_pend_c[k] = pend[a] && !(hit0 || hit1);
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_pend = rd_pend_c;
endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general-purpose register file for the pipelined MIPS datapath.
- Configurable width, depth and read-port count, with two write ports:
  - WP0: main writeback stage.
  - WP1: multi-cycle mult/div unit.
- Optional write-to-read bypass.
- Per-register pending scoreboard, so the hazard unit can stall readers of in-flight results.
- Sits between decode (reads, issue) and writeback / MD-unit (writes).

Parameters:
- DW, 32: data width in bits.
- AW, 5: address width; depth = 2**AW registers.
- NRD, 2: number of read ports (1..4).
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- rd_data  out  NRD*DW  read data; port k at [k*DW +: DW]; combinational.
- rd_pend  out  NRD  port k address has an outstanding producer; combinational.
- wr0_en  in  1  write enable, port 0.
- wr0_addr  in  AW  write address, port 0.
- wr0_data  in  DW  write data, port 0.
- wr1_en  in  1  write enable, port 1.
- wr1_addr  in  AW  write address, port 1.
- wr1_data  in  DW  write data, port 1.
- iss_en  in  1  instruction issued that will write iss_addr.
- iss_addr  in  AW  destination of the issued instruction.
- wr_conflict  out  1  registered pulse: previous cycle had both ports writing the same nonzero address.

Behaviour:
- Reset: reset sampled high at posedge clears all registers to 0, all pend bits to 0, and wr_conflict to 0. Writes and issue in that cycle are ignored.
- Register 0:
  - Never written.
  - Never pending.
  - Reads of address 0 return 0 regardless of bypass.
  - Writes and issue to address 0 are no-ops.
- Writes:
  - Committed at posedge.
  - A write is effective iff en && addr != 0.
- Same-cycle dual write to the same nonzero address:
  - WP0 wins; WP1 data is dropped.
  - wr_conflict = 1 for exactly the next cycle, otherwise 0.
  - Different addresses: both commit.
- Read data per port k (combinational, zero latency):
  - addr == 0 -> 0.
  - else if BYPASS and effective WP0 to the same addr -> wr0_data.
  - else if BYPASS and effective WP1 to the same addr -> wr1_data.
  - else stored value.
  - BYPASS=0: stored value only; new data is visible the cycle after the write.
- Scoreboard pend[r], updated at posedge:
  - set if iss_en && iss_addr == r && r != 0;
  - else cleared if an effective write (either port) targets r;
  - else held.
  - Set has priority over clear in the same cycle: the new producer supersedes the retiring one.
- rd_pend[k]:
  - = pend[addr] && !(BYPASS && an effective write to addr this cycle);
  - forced 0 for addr 0;
  - independent of the same-cycle iss_en.
- Repeated issue to an already pending register keeps it pending; there is no counting. The single pending bit is cleared by the next write.
- Writes to a non-pending register are legal and commit normally.
- All ports are fully independent; any number of read ports may alias the same address.
- Implementation: flip-flop array, no memories inferred with read latency.

Test Plan:
- Reset then read all 32 addresses on both ports -> all rd_data = 0, rd_pend = 0, wr_conflict = 0.
- WP0 writes r5 = 0x1234_5678 while port 0 reads r5:
  - BYPASS=1 -> 0x12345678 the same cycle;
  - BYPASS=0 -> old value 0 the same cycle, 0x12345678 the next cycle.
- WP0 r7 = 0xAAAA_AAAA and WP1 r7 = 0x5555_5555 in the same cycle:
  - next cycle r7 reads 0xAAAAAAAA and wr_conflict = 1;
  - the cycle after, wr_conflict = 0.
- Issue r9, next cycle read r9 -> rd_pend = 1:
  - WP1 writes r9 = 0x42 -> rd_pend = 0 that cycle (BYPASS=1), data 0x42;
  - also issue r9 and write r9 in the same cycle -> pend stays 1.
- Write r0 = 0xFFFF_FFFF and issue r0 -> reads of r0 return 0, rd_pend = 0.
- Write r3 = 0x77 and issue r4, then assert reset while WP0 writes r3 = 0x99 -> after reset r3 = 0, pend[4] = 0, r3 != 0x99.
